// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: word/line types plus the memory-arbiter
// state and owner encodings used by cache_arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] mem_bus;

    typedef enum logic [2:0] {
        arb_idle,
        arb_i_busy,
        arb_d_busy,
        arb_i_done,
        arb_d_done
    } lc3b_arb_state;

    typedef enum logic {
        arb_owner_i = 1'b0,
        arb_owner_d = 1'b1
    } lc3b_arb_owner;

    // Pick the winner among the pending requests. On contention the side
    // that did not win last time gets the port, so neither cache starves.
    function automatic lc3b_arb_owner arb_pick(input logic i_req,
                                               input logic d_req,
                                               input lc3b_arb_owner last);
        if (i_req && d_req)
            return (last == arb_owner_i) ? arb_owner_d : arb_owner_i;
        return d_req ? arb_owner_d : arb_owner_i;
    endfunction

endpackage

// File: rtl/cache_arbiter.sv
// Arbiter sharing the single physical-memory port between the I-cache and
// the D-cache. A request is latched at grant and held stable toward memory;
// the returned line is registered and presented to the owner for one cycle.
module cache_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    lc3b_arb_state           state_reg, state_next;
    lc3b_arb_owner           last_grant_reg, last_grant_next;
    lc3b_arb_owner           grant;
    logic                    op_write_reg, op_write_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [LINE_WIDTH-1:0]   wdata_reg, wdata_next;
    logic [LINE_WIDTH-1:0]   i_rdata_reg, i_rdata_next;
    logic [LINE_WIDTH-1:0]   d_rdata_reg, d_rdata_next;

    logic i_req;
    logic d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Next-state and latch-update logic; cache inputs only matter in IDLE.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        op_write_next   = op_write_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        i_rdata_next    = i_rdata_reg;
        d_rdata_next    = d_rdata_reg;
        grant           = arb_pick(i_req, d_req, last_grant_reg);

        case (state_reg)
            arb_idle: begin
                if (i_req || d_req) begin
                    last_grant_next = grant;
                    if (grant == arb_owner_d) begin
                        addr_next     = d_pmem_address;
                        wdata_next    = d_pmem_wdata;
                        // A write wins if both D-side strobes are high.
                        op_write_next = d_pmem_write;
                        state_next    = arb_d_busy;
                    end else begin
                        addr_next     = i_pmem_address;
                        op_write_next = 1'b0;
                        state_next    = arb_i_busy;
                    end
                end
            end
            arb_i_busy: begin
                if (pmem_resp) begin
                    i_rdata_next = pmem_rdata;
                    state_next   = arb_i_done;
                end
            end
            arb_d_busy: begin
                if (pmem_resp) begin
                    // Write-backs leave the D read-data register untouched.
                    if (!op_write_reg)
                        d_rdata_next = pmem_rdata;
                    state_next = arb_d_done;
                end
            end
            arb_i_done: state_next = arb_idle;
            arb_d_done: state_next = arb_idle;
            default:    state_next = arb_idle;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= arb_idle;
            last_grant_reg <= arb_owner_i;
            op_write_reg   <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            op_write_reg   <= op_write_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            i_rdata_reg    <= i_rdata_next;
            d_rdata_reg    <= d_rdata_next;
        end
    end

    // Flag the illegal simultaneous D-side read+write whenever it is sampled.
    always_ff @(posedge clk) begin
        if (!reset && state_reg == arb_idle)
            assert (!(d_pmem_read && d_pmem_write))
            else $warning("cache_arbiter: d_pmem_read and d_pmem_write both high, treated as write");
    end

    // Strobes and responses decode purely from registered state.
    assign pmem_read    = (state_reg == arb_i_busy) ||
                          ((state_reg == arb_d_busy) && !op_write_reg);
    assign pmem_write   = (state_reg == arb_d_busy) && op_write_reg;
    assign pmem_address = addr_reg;
    assign pmem_wdata   = wdata_reg;
    assign i_pmem_resp  = (state_reg == arb_i_done);
    assign d_pmem_resp  = (state_reg == arb_d_done);
    assign i_pmem_rdata = i_rdata_reg;
    assign d_pmem_rdata = d_rdata_reg;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios with literal
// expectations, then randomized cache/memory traffic against a
// transaction-level reference model compared on every falling edge.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic [127:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int tests = 0;
    int fails = 0;

    cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ---------------- reference model (transaction level) ----------------
    // A transaction is either absent, in flight (owner/addr/data/op), or
    // completing; the model tracks just that plus the round-robin memory.
    typedef enum int {T_NONE, T_FLIGHT, T_COMPLETE} txn_phase_t;
    txn_phase_t   m_phase;
    int           m_owner;      // 0 = I, 1 = D
    int           m_last;       // who won the last grant
    bit           m_is_write;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    logic [127:0] m_line [2];   // last line delivered to each cache

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= T_NONE; m_owner <= 0; m_last <= 0; m_is_write <= 0;
            m_addr <= '0; m_wdata <= '0; m_line[0] <= '0; m_line[1] <= '0;
        end else begin
            case (m_phase)
                T_NONE: begin
                    int want_i, want_d, win;
                    want_i = i_pmem_read;
                    want_d = d_pmem_read | d_pmem_write;
                    if (want_i + want_d > 0) begin
                        win = (want_i + want_d == 2) ? 1 - m_last : want_d;
                        m_owner <= win; m_last <= win; m_phase <= T_FLIGHT;
                        m_addr <= (win == 1) ? d_pmem_address : i_pmem_address;
                        m_is_write <= (win == 1) && d_pmem_write;
                        if (win == 1) m_wdata <= d_pmem_wdata;
                    end
                end
                T_FLIGHT: if (pmem_resp) begin
                    if (!m_is_write) m_line[m_owner] <= pmem_rdata;
                    m_phase <= T_COMPLETE;
                end
                default: m_phase <= T_NONE;
            endcase
        end
    end

    // Single compare process: every falling edge, all outputs vs the model.
    always @(negedge clk) begin
        chk("pmem_read",    pmem_read,    m_phase == T_FLIGHT && !m_is_write);
        chk("pmem_write",   pmem_write,   m_phase == T_FLIGHT && m_is_write);
        chk("pmem_address", pmem_address, m_addr);
        chk("pmem_wdata",   pmem_wdata,   m_wdata);
        chk("i_pmem_resp",  i_pmem_resp,  m_phase == T_COMPLETE && m_owner == 0);
        chk("d_pmem_resp",  d_pmem_resp,  m_phase == T_COMPLETE && m_owner == 1);
        chk("i_pmem_rdata", i_pmem_rdata, m_line[0]);
        chk("d_pmem_rdata", d_pmem_rdata, m_line[1]);
    end

    // ---------------- memory responder ----------------
    bit           rand_en = 0;
    bit           stray_req = 0;
    int           mem_lat = 0;
    int           mem_cnt = 0;
    logic [127:0] mem_line = '0;

    always @(negedge clk) begin
        #1;
        pmem_resp = 1'b0;
        if (pmem_read || pmem_write) begin
            if (mem_cnt >= mem_lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rand_en ? {$urandom, $urandom, $urandom, $urandom} : mem_line;
                mem_cnt    = 0;
                if (rand_en) mem_lat = $urandom_range(0, 3);
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
            if (stray_req || (rand_en && $urandom_range(0, 7) == 0)) begin
                pmem_resp  = 1'b1;
                pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------- random cache initiators ----------------
    always @(negedge clk) begin
        #1;
        if (rand_en) begin
            if (i_pmem_resp) i_pmem_read = 1'b0;
            if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
                i_pmem_read    = 1'b1;
                i_pmem_address = 16'($urandom);
            end else if ($urandom_range(0, 3) == 0) begin
                i_pmem_address = 16'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (rand_en) begin
            if (d_pmem_resp) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
            if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
                d_pmem_write   = 1'($urandom_range(0, 1));
                d_pmem_read    = !d_pmem_write;
                d_pmem_address = 16'($urandom);
                d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end else if ($urandom_range(0, 3) == 0) begin
                d_pmem_address = 16'($urandom);
                d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Wait (bounded) for a response pulse; returns at that falling edge.
    task automatic wait_resp(input bit d_side, input string nm);
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = d_side ? d_pmem_resp : i_pmem_resp;
        end
        if (!seen) chk({"timeout_", nm}, 1'b0, 1'b1);
    endtask

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        int order [$];
        reset = 1'b1;
        i_pmem_read = 0; i_pmem_address = '0;
        d_pmem_read = 0; d_pmem_write = 0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;

        repeat (2) @(negedge clk);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_address", pmem_address, 16'h0);
        chk("rst_i_resp", i_pmem_resp, 1'b0);
        chk("rst_d_rdata", d_pmem_rdata, 128'h0);
        #1 reset = 1'b0;

        // Reset asserted mid I_BUSY.
        mem_lat = 5;
        i_pmem_read = 1; i_pmem_address = 16'h2222;
        @(negedge clk);
        chk("t1_busy_read", pmem_read, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t1_async_read", pmem_read, 1'b0);
        chk("t1_async_resp", i_pmem_resp, 1'b0);
        chk("t1_async_addr", pmem_address, 16'h0);
        i_pmem_read = 0;
        @(negedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t1_no_stray_resp", i_pmem_resp, 1'b0);
        end

        // I-cache read alone.
        #1;
        mem_lat = 2; mem_line = {4{32'hDEADBEEF}};
        i_pmem_read = 1; i_pmem_address = 16'h1230;
        @(negedge clk);
        chk("t2_read", pmem_read, 1'b1);
        chk("t2_addr", pmem_address, 16'h1230);
        wait_resp(0, "t2");
        chk("t2_rdata", i_pmem_rdata, {4{32'hDEADBEEF}});
        chk("t2_d_resp", d_pmem_resp, 1'b0);
        #1 i_pmem_read = 0;
        @(negedge clk);
        chk("t2_single_pulse", i_pmem_resp, 1'b0);

        // D-cache write-back.
        #1;
        mem_lat = 1;
        d_pmem_write = 1; d_pmem_address = 16'h04A0; d_pmem_wdata = {16{8'hA5}};
        @(negedge clk);
        chk("t3_write", pmem_write, 1'b1);
        chk("t3_wdata", pmem_wdata, {16{8'hA5}});
        chk("t3_addr", pmem_address, 16'h04A0);
        wait_resp(1, "t3");
        chk("t3_d_rdata_unchanged", d_pmem_rdata, 128'h0);
        #1 d_pmem_write = 0;
        @(negedge clk);
        chk("t3_single_pulse", d_pmem_resp, 1'b0);

        // D address changes mid-transaction.
        #1;
        mem_lat = 3; mem_line = {4{32'hCAFEF00D}};
        d_pmem_read = 1; d_pmem_address = 16'h0100;
        @(negedge clk);
        #1 d_pmem_address = 16'h0200;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_addr_held", pmem_address, 16'h0100);
        end
        wait_resp(1, "t5");
        chk("t5_d_rdata", d_pmem_rdata, {4{32'hCAFEF00D}});
        #1 d_pmem_read = 0;

        // Stray pmem_resp in IDLE, then illegal read+write.
        @(negedge clk);
        stray_req = 1;
        @(negedge clk);
        stray_req = 0;
        chk("t6_stray_i", i_pmem_resp, 1'b0);
        chk("t6_stray_d", d_pmem_resp, 1'b0);
        @(negedge clk);
        chk("t6_stray_read", pmem_read, 1'b0);
        #1;
        mem_lat = 0; mem_line = {4{32'h11112222}};
        d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 16'h0300; d_pmem_wdata = {4{32'h0BADF00D}};
        @(negedge clk);
        chk("t6_both_write", pmem_write, 1'b1);
        chk("t6_both_read", pmem_read, 1'b0);
        #1 d_pmem_read = 0;
        wait_resp(1, "t6");
        chk("t6_rdata_kept", d_pmem_rdata, {4{32'hCAFEF00D}});
        #1 d_pmem_write = 0;

        // Contention after a fresh reset: D first, then strict alternation.
        reset = 1;
        @(negedge clk);
        #1 reset = 0;
        mem_lat = 1;
        i_pmem_read = 1; i_pmem_address = 16'h0AA0;
        d_pmem_read = 1; d_pmem_address = 16'h0DD0;
        for (int n = 0; n < 80 && order.size() < 6; n++) begin
            @(negedge clk);
            if (i_pmem_resp) order.push_back(0);
            if (d_pmem_resp) order.push_back(1);
        end
        chk("t4_count", 32'(order.size()), 32'd6);
        foreach (order[k])
            chk($sformatf("t4_grant%0d", k), 32'(order[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        #1 i_pmem_read = 0; d_pmem_read = 0;
        repeat (3) @(negedge clk);

        // Randomized traffic checked by the model.
        rand_en = 1;
        repeat (3000) @(negedge clk);
        rand_en = 0;
        #2;
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Arbitrates the single physical-memory port between the I-cache and the D-cache line-fill/write-back interfaces. Each cache is an initiator on a 128-bit mem_bus line protocol. This block is the responder to both caches and the single initiator toward physical memory. Requests are latched at grant and held stable toward memory. Memory data is returned to the owning cache through a registered one-cycle response.

Parameters:
ADDR_WIDTH, 16, byte address width (lc3b_word)
LINE_WIDTH, 128, line width in bits (mem_bus)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
i_pmem_address  in  16  I-cache line address
i_pmem_rdata  out  128  line returned to I-cache, valid while i_pmem_resp=1
i_pmem_resp  out  1  one-cycle completion pulse to I-cache
d_pmem_read  in  1  D-cache line read request
d_pmem_write  in  1  D-cache line write-back request
d_pmem_address  in  16  D-cache line address
d_pmem_wdata  in  128  D-cache write-back line
d_pmem_rdata  out  128  line returned to D-cache
d_pmem_resp  out  1  one-cycle completion pulse to D-cache
pmem_read  out  1  memory read strobe, held until pmem_resp
pmem_write  out  1  memory write strobe, held until pmem_resp
pmem_address  out  16  latched address toward memory
pmem_wdata  out  128  latched write data toward memory
pmem_rdata  in  128  memory read data, valid with pmem_resp
pmem_resp  in  1  memory completion, single-cycle pulse

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Outputs while reset is asserted:
  - state=IDLE, last_grant=I.
  - All resp, read and write outputs are 0.
  - pmem_address, pmem_wdata, i_pmem_rdata and d_pmem_rdata are 0.
- States: IDLE, I_BUSY, D_BUSY, I_DONE, D_DONE.
- IDLE, request detection:
  - i_req = i_pmem_read.
  - d_req = d_pmem_read | d_pmem_write.
- IDLE, grant selection:
  - Only i_req: grant I.
  - Only d_req: grant D.
  - Both: grant the side not equal to last_grant (round robin). The first contention after reset goes to D.
- IDLE, actions on grant:
  - Latch the granted address into pmem_address.
  - For D, latch d_pmem_wdata into pmem_wdata and latch the op bit (write if d_pmem_write).
  - Update last_grant.
  - Go to I_BUSY or D_BUSY.
  - pmem_read/pmem_write assert in the cycle after the grant edge (1-cycle arbitration latency).
- I_BUSY / D_BUSY:
  - Drive pmem_read or pmem_write from the latched op. They are registered or decoded from state only, never combinational from cache inputs.
  - Cache input changes are ignored while busy.
- I_BUSY / D_BUSY on pmem_resp=1:
  - Register pmem_rdata into the owner's rdata register.
  - Go to I_DONE or D_DONE.
  - pmem_read/pmem_write deassert in the DONE cycle.
- I_DONE / D_DONE:
  - Owner's resp=1 for exactly one cycle, with rdata valid.
  - Unconditionally return to IDLE.
  - The served cache's request during the DONE cycle is not sampled. The next IDLE cycle sees its next request.
- Rdata hold: the rdata registers retain their value after resp. Write-backs return the D rdata register unchanged.
- D-side op priority: d_pmem_read and d_pmem_write both high is illegal. Write takes precedence and a simulation assertion fires.
- Minimum transaction: grant edge, then ≥1 busy cycle, then DONE. Total ≥3 cycles from request to resp, given pmem_resp on the first busy cycle.
- Starvation bound: with both caches continuously requesting, grants alternate strictly I/D.
- Reset mid-transaction: immediate return to IDLE and all strobes drop. Memory must tolerate an abandoned request. No resp is issued for the aborted request.
- pmem_resp while not busy is ignored.

Decomposition:
- Add to the shared lc3b_types package:
  - mem_bus (already present).
  - A new enum lc3b_arb_state {arb_idle, arb_i_busy, arb_d_busy, arb_i_done, arb_d_done}.
  - A new typedef lc3b_arb_owner (1 bit: I=0, D=1).
- Sub-module: none. The FSM and the latch registers fit in one module.
- A thin registered mux, cache_arbiter_datapath, is permitted if the FSM/datapath split is preferred.

Test Plan:
1. Reset asserted mid I_BUSY -> same cycle: pmem_read=0, i_pmem_resp=0; after release, state IDLE and no stray resp.
2. I-cache read alone, address 0x1230, memory returns 0xDEADBEEF_...x4 after 3 cycles:
   - -> pmem_read=1 with pmem_address=0x1230 from cycle 1.
   - -> i_pmem_resp single pulse carrying that line.
   - -> d_pmem_resp stays 0.
3. D-cache write, address 0x4A0, wdata pattern A5A5...:
   - -> pmem_write=1 with the latched data.
   - -> d_pmem_resp one-cycle pulse after pmem_resp.
   - -> d_pmem_rdata unchanged.
4. Both caches request on the same cycle after reset -> D granted first, then I. Under continuous requests, grants alternate for 6 transactions.
5. D-cache changes d_pmem_address from 0x100 to 0x200 mid-D_BUSY -> pmem_address stays 0x100 until DONE.
6. pmem_resp pulsed in IDLE -> no resp output. d_pmem_read and d_pmem_write both high -> treated as write and the assertion fires.
